// File: rtl/gift_pkg.sv
// Shared GIFT datapath definitions: block width, serializer state encoding
// and the word-counter width helper.
package gift_pkg;

    localparam int GIFT_BLOCK_W = 128;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } serState_t;

    // Counter needs at least one bit even when a block is a single word.
    function automatic int cntWidth(input int nWords);
        return (nWords <= 2) ? 1 : $clog2(nWords);
    endfunction

endpackage

// File: rtl/gift_out_serializer.sv
// Captures one 128-bit ciphertext block and streams it out MS word first over
// valid/ready, accepting the next block in the same cycle as the final word.
module gift_out_serializer
    import gift_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                    inClk,
    input  logic                    inRstN,
    input  logic                    inLoad,
    input  logic [GIFT_BLOCK_W-1:0] inData,
    output logic                    outLoadReady,
    output logic [WORD_W-1:0]       outWord,
    output logic                    outValid,
    input  logic                    inReady,
    output logic                    outLast,
    output logic                    outDone
);

    localparam int NWORDS = GIFT_BLOCK_W / WORD_W;
    localparam int CNT_W  = cntWidth(NWORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORDS - 1);

    generate
        if (!(WORD_W == 8 || WORD_W == 16 || WORD_W == 32 || WORD_W == 64 || WORD_W == 128))
        begin : gIllegalWordW
            $error("gift_out_serializer: WORD_W must be 8, 16, 32, 64 or 128");
        end
    endgenerate

    serState_t               stateQ, stateD;
    logic [GIFT_BLOCK_W-1:0] shregQ, shregD, shregShift;
    logic [CNT_W-1:0]        cntQ, cntD;
    logic                    doneQ;
    logic                    xfer, lastXfer, loadAccept;

    // A single-word block has nothing left to shift in after its transfer.
    generate
        if (NWORDS == 1) begin : gNoShift
            assign shregShift = '0;
        end else begin : gShift
            assign shregShift = {shregQ[GIFT_BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    endgenerate

    assign outValid     = (stateQ == SEND);
    assign outLast      = (stateQ == SEND) && (cntQ == LAST_CNT);
    assign outWord      = shregQ[GIFT_BLOCK_W-1 -: WORD_W];
    assign outDone      = doneQ;
    assign outLoadReady = (stateQ == IDLE) || (outLast && inReady);

    assign xfer       = outValid && inReady;
    assign lastXfer   = xfer && outLast;
    assign loadAccept = inLoad && outLoadReady;

    always_comb begin
        stateD = stateQ;
        shregD = shregQ;
        cntD   = cntQ;
        if (loadAccept) begin
            stateD = SEND;
            shregD = inData;
            cntD   = '0;
        end else if (lastXfer) begin
            stateD = IDLE;
            shregD = shregShift;
            cntD   = '0;
        end else if (xfer) begin
            shregD = shregShift;
            cntD   = cntQ + CNT_W'(1);
        end
    end

    // Partial blocks are dropped on reset rather than resumed.
    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            stateQ <= IDLE;
            shregQ <= '0;
            cntQ   <= '0;
            doneQ  <= 1'b0;
        end else begin
            stateQ <= stateD;
            shregQ <= shregD;
            cntQ   <= cntD;
            doneQ  <= lastXfer;
        end
    end

endmodule

// File: tb/tb_gift_out_serializer.sv
// Scoreboard bench for gift_out_serializer at WORD_W = 32, 8 and 128.
module tb_gift_out_serializer;

    typedef struct packed {
        logic [127:0] word;
        logic         last;
    } exp_t;

    localparam logic [127:0] B1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] B2 = 128'hFFFFFFFF_FFFFFFFF_00000000_00000000;

    logic inClk  = 1'b0;
    logic inRstN = 1'b0;

    logic         load32 = 0, ready32 = 0, lr32, valid32, last32, done32;
    logic [127:0] data32 = '0;
    logic [31:0]  word32;
    logic         load8 = 0, ready8 = 0, lr8, valid8, last8, done8;
    logic [127:0] data8 = '0;
    logic [7:0]   word8;
    logic         load128 = 0, ready128 = 0, lr128, valid128, last128, done128;
    logic [127:0] data128 = '0;
    logic [127:0] word128;

    int   testsRun = 0;
    int   testsFailed = 0;
    exp_t expQ [3][$];
    logic held [3] = '{0, 0, 0};
    logic [127:0] heldWord [3];
    logic heldLast [3];
    logic prevLast [3] = '{0, 0, 0};
    int   doneCount [3] = '{0, 0, 0};
    int   xferCount [3] = '{0, 0, 0};

    always #5 inClk = ~inClk;

    gift_out_serializer #(.WORD_W(32)) dut32 (
        .inClk(inClk), .inRstN(inRstN), .inLoad(load32), .inData(data32),
        .outLoadReady(lr32), .outWord(word32), .outValid(valid32),
        .inReady(ready32), .outLast(last32), .outDone(done32));

    gift_out_serializer #(.WORD_W(8)) dut8 (
        .inClk(inClk), .inRstN(inRstN), .inLoad(load8), .inData(data8),
        .outLoadReady(lr8), .outWord(word8), .outValid(valid8),
        .inReady(ready8), .outLast(last8), .outDone(done8));

    gift_out_serializer #(.WORD_W(128)) dut128 (
        .inClk(inClk), .inRstN(inRstN), .inLoad(load128), .inData(data128),
        .outLoadReady(lr128), .outWord(word128), .outValid(valid128),
        .inReady(ready128), .outLast(last128), .outDone(done128));

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        testsRun++;
        if (act !== req) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic pushExp(input int idx, input logic [127:0] w, input logic last);
        exp_t e;
        e.word = w;
        e.last = last;
        expQ[idx].push_back(e);
    endtask

    task automatic pushB1x32();
        pushExp(0, 128'h01234567, 1'b0);
        pushExp(0, 128'h89ABCDEF, 1'b0);
        pushExp(0, 128'hFEDCBA98, 1'b0);
        pushExp(0, 128'h76543210, 1'b1);
    endtask

    task automatic monitorStep(input int idx, input logic valid, input logic ready, input logic last,
                               input logic done, input logic loadReady, input logic [127:0] word);
        exp_t e;
        if (!inRstN) begin
            expQ[idx].delete();
            prevLast[idx] = 1'b0;
            held[idx] = 1'b0;
            return;
        end
        checkOutput($sformatf("outDone[%0d]", idx), 128'(done), 128'(prevLast[idx]));
        checkOutput($sformatf("outLoadReady[%0d]", idx), 128'(loadReady), 128'(!valid || (last && ready)));
        if (held[idx]) begin
            checkOutput($sformatf("stallValid[%0d]", idx), 128'(valid), 128'(1'b1));
            checkOutput($sformatf("stallWord[%0d]", idx), word, heldWord[idx]);
            checkOutput($sformatf("stallLast[%0d]", idx), 128'(last), 128'(heldLast[idx]));
        end
        if (valid && ready) begin
            xferCount[idx]++;
            if (expQ[idx].size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedWord[%0d]: got %h, required no transfer", idx, word);
            end else begin
                e = expQ[idx].pop_front();
                checkOutput($sformatf("word[%0d]", idx), word, e.word);
                checkOutput($sformatf("last[%0d]", idx), 128'(last), 128'(e.last));
            end
        end
        held[idx]     = valid && !ready;
        heldWord[idx] = word;
        heldLast[idx] = last;
        prevLast[idx] = valid && ready && last;
        if (done) doneCount[idx]++;
    endtask

    always @(negedge inClk) begin
        monitorStep(0, valid32, ready32, last32, done32, lr32, 128'(word32));
        monitorStep(1, valid8, ready8, last8, done8, lr8, 128'(word8));
        monitorStep(2, valid128, ready128, last128, done128, lr128, word128);
    end

    task automatic applyStimulus();
        @(posedge inClk);
        #1;
    endtask

    initial begin
        logic [7:0] bytes8 [16];
        logic       pattern [7];
        int         base;
        logic       found;
        bytes8  = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
                    8'hFE, 8'hDC, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10};
        pattern = '{1, 0, 0, 1, 0, 1, 1};

        applyStimulus();
        applyStimulus();
        checkOutput("rstValid", 128'(valid32), 128'(1'b0));
        checkOutput("rstWord", 128'(word32), 128'h0);
        checkOutput("rstLast", 128'(last32), 128'(1'b0));
        checkOutput("rstDone", 128'(done32), 128'(1'b0));
        checkOutput("rstLoadReady", 128'(lr32), 128'(1'b1));
        inRstN = 1'b1;

        // Straight stream with inReady held high
        applyStimulus();
        ready32 = 1; load32 = 1; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        checkOutput("latencyValid", 128'(valid32), 128'(1'b1));
        checkOutput("latencyWord", 128'(word32), 128'h01234567);
        repeat (6) applyStimulus();
        checkOutput("doneAfterStream", 128'(doneCount[0]), 128'(1));

        // Stalled stream
        base = xferCount[0];
        load32 = 1; ready32 = 0; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        for (int i = 0; i < 7; i++) begin
            ready32 = pattern[i];
            applyStimulus();
        end
        ready32 = 1;
        repeat (3) applyStimulus();
        checkOutput("stallXfers", 128'(xferCount[0] - base), 128'(4));

        // Back-to-back blocks
        base = doneCount[0];
        load32 = 1; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (last32) found = 1;
            else applyStimulus();
        end
        if (!found) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL b2bWaitLast: got no outLast, required outLast within 10 cycles");
        end
        load32 = 1; data32 = B2;
        pushExp(0, 128'hFFFFFFFF, 1'b0);
        pushExp(0, 128'hFFFFFFFF, 1'b0);
        pushExp(0, 128'h00000000, 1'b0);
        pushExp(0, 128'h00000000, 1'b1);
        applyStimulus();
        load32 = 0;
        checkOutput("b2bValid", 128'(valid32), 128'(1'b1));
        checkOutput("b2bWord", 128'(word32), 128'hFFFFFFFF);
        repeat (6) applyStimulus();
        checkOutput("b2bDonePulses", 128'(doneCount[0] - base), 128'(2));

        // Load attempt mid-block is ignored
        load32 = 1; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        applyStimulus();
        applyStimulus();
        load32 = 1; data32 = B2;
        checkOutput("midLoadReady", 128'(lr32), 128'(1'b0));
        applyStimulus();
        load32 = 0;
        repeat (5) applyStimulus();
        checkOutput("midQueueEmpty", 128'(expQ[0].size()), 128'(0));

        // Reset mid-block, then a fresh block
        load32 = 1; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        repeat (3) applyStimulus();
        inRstN = 1'b0;
        #1;
        checkOutput("midRstValid", 128'(valid32), 128'(1'b0));
        checkOutput("midRstWord", 128'(word32), 128'h0);
        checkOutput("midRstLast", 128'(last32), 128'(1'b0));
        checkOutput("midRstDone", 128'(done32), 128'(1'b0));
        checkOutput("midRstLoadReady", 128'(lr32), 128'(1'b1));
        applyStimulus();
        inRstN = 1'b1;
        applyStimulus();
        load32 = 1; data32 = B1; pushB1x32();
        applyStimulus();
        load32 = 0;
        checkOutput("postRstWord", 128'(word32), 128'h01234567);
        repeat (6) applyStimulus();
        checkOutput("postRstQueueEmpty", 128'(expQ[0].size()), 128'(0));

        // Byte-wide serializer
        ready8 = 1; load8 = 1; data8 = B1;
        for (int i = 0; i < 16; i++) pushExp(1, 128'(bytes8[i]), i == 15);
        applyStimulus();
        load8 = 0;
        repeat (18) applyStimulus();
        checkOutput("w8QueueEmpty", 128'(expQ[1].size()), 128'(0));
        checkOutput("w8DonePulses", 128'(doneCount[1]), 128'(1));

        // Full-width serializer: one word, always last
        ready128 = 1; load128 = 1; data128 = B1;
        pushExp(2, B1, 1'b1);
        applyStimulus();
        load128 = 0;
        checkOutput("w128Valid", 128'(valid128), 128'(1'b1));
        checkOutput("w128Last", 128'(last128), 128'(1'b1));
        checkOutput("w128Word", word128, B1);
        applyStimulus();
        checkOutput("w128Done", 128'(done128), 128'(1'b1));
        checkOutput("w128ValidAfter", 128'(valid128), 128'(1'b0));
        repeat (2) applyStimulus();
        checkOutput("w128QueueEmpty", 128'(expQ[2].size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/gift_out_serializer.md
# gift_out_serializer

Downstream of the 128-bit ciphertext output register in the GIFT datapath. The block captures one 128-bit block and streams it out as NWORDS narrow words over a valid/ready interface, most-significant word first. It accepts a new block back-to-back with the final word of the previous one, so a continuous stream runs with no bubble.

## Interface
- WORD_W, default 32: output word width. Legal values are 8, 16, 32, 64 and 128. NWORDS = 128/WORD_W.
- inClk  in  1  clock; all state changes on the rising edge.
- inRstN  in  1  asynchronous, active-low reset.
- inLoad  in  1  request to capture inData. Honoured only in a cycle where outLoadReady=1.
- inData  in  128  block to serialize. Sampled only on an accepted load.
- outLoadReady  out  1  block can accept a load this cycle. Combinational; see Operation.
- outWord  out  WORD_W  current output word.
- outValid  out  1  outWord is valid.
- inReady  in  1  downstream accepts outWord.
- outLast  out  1  outWord is the final word of the block. Qualified by outValid.
- outDone  out  1  one-cycle pulse in the cycle after the final word transfers.

## Operation
- Load accepted = inLoad && outLoadReady.
- outLoadReady = (state==IDLE) || (state==SEND && outLast && inReady).
- This is a combinational path from inReady to outLoadReady. It is documented and intended.
- States:
  - IDLE: outValid=0. An accepted load moves to SEND.
  - SEND: outValid=1. Each transfer (outValid && inReady) shifts the register left by WORD_W and increments the word counter.
  - Final-word transfer with no accepted load: go to IDLE.
  - Final-word transfer with an accepted load: stay in SEND, reload the shift register, clear the counter.
- Datapath:
  - 128-bit shift register. outWord = shreg[127 -: WORD_W].
  - Word counter width max(1, clog2(NWORDS)).
  - outLast = (cnt == NWORDS-1) && state==SEND.
  - For NWORDS=1, outLast=1 on every valid word.
- Handshake rules:
  - Once outValid is asserted, it stays high and outWord/outLast stay stable until transfer.
  - outValid never depends combinationally on inReady.
- inLoad while outLoadReady=0 is ignored: no capture, no state change. Upstream must hold its data and retry.
- outDone is registered: high for exactly one cycle after each final-word transfer, including back-to-back blocks.
- Reset, asserted at any time, including mid-block: state=IDLE, shreg=0, cnt=0, outValid=0, outWord=0, outLast=0, outDone=0. outLoadReady=1 follows combinationally. A partial block is discarded, not resumed.

## Timing
- Accepted load in cycle N: outValid=1 with word 0 in cycle N+1.
- Latency to first word is 1 cycle.
- With inReady held at 1 (WORD_W=32): words in N+1..N+4, outLast in N+4, outDone in N+5.
- Back-to-back load accepted in N+4: next block's word 0 in N+5. Sustained throughput is 128 bits per NWORDS cycles.
- Each cycle inReady=0 while outValid=1 stretches the sequence by one cycle and freezes all outputs.
- outDone and outLoadReady may both be high in N+5 (IDLE). This is legal.

## Structure
- Shared package gift_pkg:
  - GIFT_BLOCK_W = 128.
  - State enum {IDLE, SEND}, 1-bit encoding.
  - Function computing counter width from NWORDS.
- Single module, no sub-module. The counter and shift register are too small to split out.
- WORD_W legality is checked by an elaboration-time assertion. An illegal value fails elaboration.

## Test plan
- Reset, then load 128'h0123456789ABCDEF_FEDCBA9876543210, inReady=1, WORD_W=32:
  - Required: 32'h01234567, 89ABCDEF, FEDCBA98, 76543210 on consecutive cycles.
  - outLast only on 76543210; outDone one cycle later.
- Same block with inReady toggling 1,0,0,1,0,1,1: each word is held stable while stalled, order is unchanged, and exactly 4 transfers occur.
- Back-to-back: second block 128'hFFFF...0000 loaded in the final-word cycle. Required: its word 32'hFFFFFFFF immediately follows 76543210 with no gap, and outDone pulses twice.
- inLoad asserted mid-block (after word 1) with different data: ignored, and the original block completes unchanged.
- Reset asserted after word 2 transfers: all outputs 0 and outLoadReady=1 immediately; a fresh load then streams from word 0.
- WORD_W=8 and WORD_W=128 with the same block:
  - 8: 16 bytes 8'h01, 8'h23 ... 8'h10.
  - 128: a single word with outLast=1, and outDone in the following cycle.
